// File: rtl/axil4_rr_arbiter_2to1_if.sv
// AXI4-Lite channel bundle shared by the requester ports and the downstream port.
interface axil4_rr_arbiter_2to1_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/axil4_rr_arbiter_2to1.sv
// Two-requester AXI4-Lite arbiter: independent round-robin read and write paths,
// one outstanding transaction per direction, responses routed to the owner.
module axil4_rr_arbiter_2to1 #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  axil4_rr_arbiter_2to1_if.slave   s0,
  axil4_rr_arbiter_2to1_if.slave   s1,
  axil4_rr_arbiter_2to1_if.master  m,
  output logic [1:0]               rd_grant,
  output logic [1:0]               wr_grant
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_RESP} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_XFER, WR_RESP} wr_state_t;

  rd_state_t  rd_state, rd_state_d;
  wr_state_t  wr_state, wr_state_d;
  logic [1:0] rd_grant_d, wr_grant_d;
  logic       rd_prio, rd_prio_d, wr_prio, wr_prio_d;
  logic       aw_done, aw_done_d, w_done, w_done_d;
  logic       aw_fire, w_fire;

  // Tie goes to prio; a lone request wins outright.
  function automatic logic [1:0] pick_grant(input logic req0, input logic req1, input logic prio);
    if (req0 && req1) return prio ? 2'b10 : 2'b01;
    else if (req1)    return 2'b10;
    else              return 2'b01;
  endfunction

  assign aw_fire = m.awvalid && m.awready;
  assign w_fire  = m.wvalid && m.wready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
      rd_grant <= 2'b00;
      wr_grant <= 2'b00;
      rd_prio  <= 1'b0;
      wr_prio  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      rd_state <= rd_state_d;
      wr_state <= wr_state_d;
      rd_grant <= rd_grant_d;
      wr_grant <= wr_grant_d;
      rd_prio  <= rd_prio_d;
      wr_prio  <= wr_prio_d;
      aw_done  <= aw_done_d;
      w_done   <= w_done_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state;
    rd_grant_d = rd_grant;
    rd_prio_d  = rd_prio;
    case (rd_state)
      RD_IDLE: if (s0.arvalid || s1.arvalid) begin
        rd_state_d = RD_ADDR;
        rd_grant_d = pick_grant(s0.arvalid, s1.arvalid, rd_prio);
      end
      RD_ADDR: if (m.arvalid && m.arready) rd_state_d = RD_RESP;
      RD_RESP: if (m.rvalid && m.rready) begin
        rd_state_d = RD_IDLE;
        rd_prio_d  = ~rd_grant[1];
        rd_grant_d = 2'b00;
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state;
    wr_grant_d = wr_grant;
    wr_prio_d  = wr_prio;
    aw_done_d  = aw_done;
    w_done_d   = w_done;
    case (wr_state)
      WR_IDLE: if (s0.awvalid || s0.wvalid || s1.awvalid || s1.wvalid) begin
        wr_state_d = WR_XFER;
        wr_grant_d = pick_grant(s0.awvalid || s0.wvalid, s1.awvalid || s1.wvalid, wr_prio);
      end
      WR_XFER: begin
        aw_done_d = aw_done || aw_fire;
        w_done_d  = w_done || w_fire;
        if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
      end
      WR_RESP: if (m.bvalid && m.bready) begin
        wr_state_d = WR_IDLE;
        wr_prio_d  = ~wr_grant[1];
        wr_grant_d = 2'b00;
        aw_done_d  = 1'b0;
        w_done_d   = 1'b0;
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read-side mux: payload follows the grant, valid/ready only in the matching phase.
  always_comb begin
    m.araddr   = AXI_ADDR_WIDTH'(0);
    m.arprot   = 3'b000;
    m.arvalid  = 1'b0;
    m.rready   = 1'b0;
    s0.arready = 1'b0;
    s1.arready = 1'b0;
    s0.rvalid  = 1'b0;
    s1.rvalid  = 1'b0;
    s0.rdata   = m.rdata;
    s1.rdata   = m.rdata;
    s0.rresp   = m.rresp;
    s1.rresp   = m.rresp;
    if (rd_grant[0]) begin
      m.araddr = s0.araddr;
      m.arprot = s0.arprot;
    end else if (rd_grant[1]) begin
      m.araddr = s1.araddr;
      m.arprot = s1.arprot;
    end
    case (rd_state)
      RD_ADDR: if (rd_grant[1]) begin
        m.arvalid  = s1.arvalid;
        s1.arready = m.arready;
      end else begin
        m.arvalid  = s0.arvalid;
        s0.arready = m.arready;
      end
      RD_RESP: if (rd_grant[1]) begin
        s1.rvalid = m.rvalid;
        m.rready  = s1.rready;
      end else begin
        s0.rvalid = m.rvalid;
        m.rready  = s0.rready;
      end
      default: ;
    endcase
  end

  // Write-side mux: AW and W each masked once their downstream handshake is done.
  always_comb begin
    m.awaddr   = AXI_ADDR_WIDTH'(0);
    m.awprot   = 3'b000;
    m.awvalid  = 1'b0;
    m.wdata    = AXI_DATA_WIDTH'(0);
    m.wstrb    = STRB_WIDTH'(0);
    m.wvalid   = 1'b0;
    m.bready   = 1'b0;
    s0.awready = 1'b0;
    s1.awready = 1'b0;
    s0.wready  = 1'b0;
    s1.wready  = 1'b0;
    s0.bvalid  = 1'b0;
    s1.bvalid  = 1'b0;
    s0.bresp   = m.bresp;
    s1.bresp   = m.bresp;
    if (wr_grant[0]) begin
      m.awaddr = s0.awaddr;
      m.awprot = s0.awprot;
      m.wdata  = s0.wdata;
      m.wstrb  = s0.wstrb;
    end else if (wr_grant[1]) begin
      m.awaddr = s1.awaddr;
      m.awprot = s1.awprot;
      m.wdata  = s1.wdata;
      m.wstrb  = s1.wstrb;
    end
    case (wr_state)
      WR_XFER: if (wr_grant[1]) begin
        m.awvalid  = s1.awvalid && !aw_done;
        s1.awready = m.awready && !aw_done;
        m.wvalid   = s1.wvalid && !w_done;
        s1.wready  = m.wready && !w_done;
      end else begin
        m.awvalid  = s0.awvalid && !aw_done;
        s0.awready = m.awready && !aw_done;
        m.wvalid   = s0.wvalid && !w_done;
        s0.wready  = m.wready && !w_done;
      end
      WR_RESP: if (wr_grant[1]) begin
        s1.bvalid = m.bvalid;
        m.bready  = s1.bready;
      end else begin
        s0.bvalid = m.bvalid;
        m.bready  = s0.bready;
      end
      default: ;
    endcase
  end
endmodule
